// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: passive snooper for the 4-bit HD44780 character-LCD bus.
// Rebuilds bytes from nibble strobes on the falling edge of LCD_E.
// Decodes uppercase hex digits written to the display back into a 16-bit word.
module lcd_bus_monitor #(
   parameter int SYNC_STAGES = 2,  // synchronizer depth on every bus input, 2..4
   parameter int WORD_DIGITS = 4   // hex digits per word_out (fixed for 16 bits)
) (
   input  logic        clk,
   input  logic        reset,       // asynchronous, active low
   input  logic [3:0]  sf_d,
   input  logic        lcd_e,
   input  logic        lcd_rs,
   input  logic        lcd_rw,
   output logic [7:0]  byte_data,
   output logic        byte_rs,
   output logic        byte_valid,
   output logic [15:0] word_out,
   output logic        word_valid,
   output logic        proto_err
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,  // power-on 8-bit phase, single nibbles only
      ST_HI   = 2'd1,  // waiting for the high nibble of a byte
      ST_LO   = 2'd2   // high nibble held, waiting for the low nibble
   } state_t;

   localparam logic [1:0] LAST_DIGIT = 2'(WORD_DIGITS - 1);

   // Synchronizer chains: stage 0 samples the pin, stage SYNC_STAGES-1 is used.
   logic [SYNC_STAGES-1:0][3:0] d_sync_q;
   logic [SYNC_STAGES-1:0]      e_sync_q;
   logic [SYNC_STAGES-1:0]      rs_sync_q;
   logic [SYNC_STAGES-1:0]      rw_sync_q;
   logic                        e_prev_q;

   logic [3:0] nib;
   logic       rs_s;
   logic       rw_s;
   logic       strobe;

   state_t      state_q, state_d;
   logic [3:0]  hi_q, hi_d;
   logic        hi_rs_q, hi_rs_d;
   logic [7:0]  byte_data_q, byte_data_d;
   logic        byte_rs_q, byte_rs_d;
   logic        byte_valid_q, byte_valid_d;
   logic [15:0] word_out_q, word_out_d;
   logic        word_valid_q, word_valid_d;
   logic        proto_err_q, proto_err_d;
   logic [15:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;

   logic [7:0]  byte_w;
   logic [15:0] acc_new;
   logic [4:0]  dig;

   // Map an ASCII byte to {is_hex_digit, value}; only '0'-'9' and 'A'-'F' qualify.
   function automatic logic [4:0] hex_digit(input logic [7:0] b);
      logic [4:0] r;
      r = 5'd0;
      if (b >= 8'h30 && b <= 8'h39) begin
         r = {1'b1, b[3:0]};
      end else if (b >= 8'h41 && b <= 8'h46) begin
         r = {1'b1, b[3:0] + 4'd9};
      end
      return r;
   endfunction

   assign nib    = d_sync_q[SYNC_STAGES-1];
   assign rs_s   = rs_sync_q[SYNC_STAGES-1];
   assign rw_s   = rw_sync_q[SYNC_STAGES-1];
   assign strobe = e_prev_q & ~e_sync_q[SYNC_STAGES-1];

   // Shift every bus input through its synchronizer and remember the last E level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_sync_q  <= '0;
         e_sync_q  <= '0;
         rs_sync_q <= '0;
         rw_sync_q <= '0;
         e_prev_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let each stage take the previous stage's old value.
         d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], sf_d};
         e_sync_q  <= {e_sync_q[SYNC_STAGES-2:0], lcd_e};
         rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
         rw_sync_q <= {rw_sync_q[SYNC_STAGES-2:0], lcd_rw};
         e_prev_q  <= e_sync_q[SYNC_STAGES-1];
      end
   end

   // Next-state, byte assembly and hex decode on each strobe.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d      = state_q;
      hi_d         = hi_q;
      hi_rs_d      = hi_rs_q;
      byte_data_d  = byte_data_q;
      byte_rs_d    = byte_rs_q;
      byte_valid_d = 1'b0;
      word_out_d   = word_out_q;
      word_valid_d = 1'b0;
      proto_err_d  = 1'b0;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      byte_w       = {hi_q, nib};
      dig          = hex_digit(byte_w);
      acc_new      = {acc_q[11:0], dig[3:0]};

      if (strobe) begin
         if (rw_s) begin
            // Reads are not decoded; flag them and leave everything else alone.
            proto_err_d = 1'b1;
         end else begin
            unique case (state_q)
               ST_INIT: begin
                  if (rs_s) begin
                     proto_err_d = 1'b1;
                  end else if (nib == 4'h2) begin
                     state_d = ST_HI;
                  end
               end
               ST_HI: begin
                  hi_d    = nib;
                  hi_rs_d = rs_s;
                  state_d = ST_LO;
               end
               ST_LO: begin
                  if (rs_s == hi_rs_q) begin
                     byte_data_d  = byte_w;
                     byte_rs_d    = rs_s;
                     byte_valid_d = 1'b1;
                     state_d      = ST_HI;
                     if (rs_s) begin
                        if (dig[4]) begin
                           if (cnt_q == LAST_DIGIT) begin
                              word_out_d   = acc_new;
                              word_valid_d = 1'b1;
                              cnt_d        = 2'd0;
                           end else begin
                              cnt_d = cnt_q + 2'd1;
                           end
                           acc_d = acc_new;
                        end else begin
                           cnt_d = 2'd0;
                           acc_d = '0;
                        end
                     end else if (byte_w == 8'h01 || byte_w[7]) begin
                        // Clear-display and set-DDRAM-address restart the digit run.
                        cnt_d = 2'd0;
                        acc_d = '0;
                     end
                  end else begin
                     // RS changed mid-byte: drop the old high nibble, this one replaces it.
                     proto_err_d = 1'b1;
                     hi_d        = nib;
                     hi_rs_d     = rs_s;
                  end
               end
               default: state_d = ST_INIT;
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_INIT;
         hi_q         <= '0;
         hi_rs_q      <= 1'b0;
         byte_data_q  <= '0;
         byte_rs_q    <= 1'b0;
         byte_valid_q <= 1'b0;
         word_out_q   <= '0;
         word_valid_q <= 1'b0;
         proto_err_q  <= 1'b0;
         acc_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         hi_rs_q      <= hi_rs_d;
         byte_data_q  <= byte_data_d;
         byte_rs_q    <= byte_rs_d;
         byte_valid_q <= byte_valid_d;
         word_out_q   <= word_out_d;
         word_valid_q <= word_valid_d;
         proto_err_q  <= proto_err_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
      end
   end

   assign byte_data  = byte_data_q;
   assign byte_rs    = byte_rs_q;
   assign byte_valid = byte_valid_q;
   assign word_out   = word_out_q;
   assign word_valid = word_valid_q;
   assign proto_err  = proto_err_q;

endmodule
